// File: rtl/ic_pkg.sv
// ic_pkg: shared types for the ic/ timer library.
package ic_pkg;
    typedef enum logic [1:0] {IDLE, TIMING, HOLD} oneshot_state_t;
endpackage

// File: rtl/oneshot_555.sv
// oneshot_555: clocked 555 monostable; a low trigger starts a COUNTS-cycle high pulse on OUT,
// stretched while the trigger stays low, non-retriggerable while timing.
module oneshot_555
    import ic_pkg::*;
#(
    parameter int BIT_WIDTH = 4,
    parameter int COUNTS    = 12
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic TRG_N,
    output logic OUT
);
    localparam logic [BIT_WIDTH-1:0] LAST = BIT_WIDTH'(COUNTS - 1);

    if (COUNTS < 1 || COUNTS > 2**BIT_WIDTH - 1) begin : g_bad_counts
        $error("oneshot_555: COUNTS must be in 1 .. 2**BIT_WIDTH-1");
    end

    oneshot_state_t       state;
    logic [BIT_WIDTH-1:0] count;

    // The counter parks at LAST, so it never wraps; it is reloaded on the next trigger.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            count <= '0;
            OUT   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!TRG_N) begin
                    state <= TIMING;
                    count <= '0;
                    OUT   <= 1'b1;
                end
                TIMING: if (count == LAST) begin
                    state <= TRG_N ? IDLE : HOLD;
                    OUT   <= !TRG_N;
                end else begin
                    count <= count + 1'b1;
                end
                HOLD: if (TRG_N) begin
                    state <= IDLE;
                    OUT   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    OUT   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_oneshot_555.sv
// tb_oneshot_555: directed and random checks of oneshot_555 (default and COUNTS=1) against a pulse-length model.
module tb_oneshot_555;
    import ic_pkg::*;

    logic CLK = 1'b0;
    logic RST_N, TRG_N, TRG1_N, OUT, OUT1;
    int   n_checks = 0;
    int   n_fail = 0;

    oneshot_555 dut (.CLK(CLK), .RST_N(RST_N), .TRG_N(TRG_N), .OUT(OUT));
    oneshot_555 #(.BIT_WIDTH(1), .COUNTS(1)) dut1 (.CLK(CLK), .RST_N(RST_N), .TRG_N(TRG1_N), .OUT(OUT1));

    always #50 CLK = ~CLK;

    // Model: how many cycles the pulse has been high; it may only end once that reaches COUNTS
    // and the trigger is high.
    logic m_out, m_out1;
    int   m_len, m_len1;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_out <= 1'b0;
            m_len <= 0;
        end else if (!m_out) begin
            if (!TRG_N) begin
                m_out <= 1'b1;
                m_len <= 1;
            end
        end else if (m_len >= 12 && TRG_N) begin
            m_out <= 1'b0;
        end else if (m_len < 12) begin
            m_len <= m_len + 1;
        end
    end

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_out1 <= 1'b0;
            m_len1 <= 0;
        end else if (!m_out1) begin
            if (!TRG1_N) begin
                m_out1 <= 1'b1;
                m_len1 <= 1;
            end
        end else if (m_len1 >= 1 && TRG1_N) begin
            m_out1 <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge CLK);
            chk("out_model", OUT, m_out);
            chk("out1_model", OUT1, m_out1);
        end
    endtask

    initial begin
        RST_N = 1'b0; TRG_N = 1'b1; TRG1_N = 1'b1;
        cyc(2);
        chk("reset_out", OUT, 1'b0);
        RST_N = 1'b1;
        cyc(3);
        chk("post_reset_out", OUT, 1'b0);
        // 500 ns: basic pulse, then a non-retriggering pulse at 1000 ns
        TRG_N = 1'b0; cyc(1); TRG_N = 1'b1;
        chk("rise_550", OUT, 1'b1);
        cyc(4);
        TRG_N = 1'b0; cyc(1); TRG_N = 1'b1;
        cyc(6);
        chk("high_1700", OUT, 1'b1);
        cyc(1);
        chk("fall_1750", OUT, 1'b0);
        cyc(2);
        chk("low_after", OUT, 1'b0);
        // 2000 ns: trigger held 20 cycles -> HOLD stretches the pulse
        TRG_N = 1'b0;
        cyc(20);
        chk("held_high", OUT, 1'b1);
        chk("hold_state", dut.state == HOLD, 1'b1);
        TRG_N = 1'b1;
        cyc(1);
        chk("held_fall", OUT, 1'b0);
        // reset mid-pulse
        TRG_N = 1'b0; cyc(1); TRG_N = 1'b1;
        cyc(3);
        chk("mid_pulse_high", OUT, 1'b1);
        RST_N = 1'b0;
        #1;
        chk("async_reset_out", OUT, 1'b0);
        chk("async_reset_model", OUT, m_out);
        cyc(2);
        RST_N = 1'b1;
        cyc(3);
        chk("after_reset_low", OUT, 1'b0);
        // glitch between edges is ignored
        #10 TRG_N = 1'b0; TRG1_N = 1'b0;
        #10 TRG_N = 1'b1; TRG1_N = 1'b1;
        cyc(3);
        chk("glitch_out", OUT, 1'b0);
        chk("glitch_out1", OUT1, 1'b0);
        // back-to-back: trigger already low on the edge after OUT falls
        TRG_N = 1'b0; cyc(1); TRG_N = 1'b1;
        cyc(12);
        chk("b2b_fallen", OUT, 1'b0);
        TRG_N = 1'b0; cyc(1); TRG_N = 1'b1;
        chk("b2b_retrig", OUT, 1'b1);
        cyc(12);
        chk("b2b_second_fall", OUT, 1'b0);
        // COUNTS=1: one-cycle pulses
        TRG1_N = 1'b0; cyc(1); TRG1_N = 1'b1;
        chk("c1_high", OUT1, 1'b1);
        cyc(1);
        chk("c1_low", OUT1, 1'b0);
        TRG1_N = 1'b0; cyc(1); TRG1_N = 1'b1;
        chk("c1_again_high", OUT1, 1'b1);
        cyc(1);
        chk("c1_again_low", OUT1, 1'b0);
        // random triggers on both instances, occasional async reset
        for (int i = 0; i < 400; i++) begin
            TRG_N  = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
            TRG1_N = ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 99) == 0) begin
                #20 RST_N = 1'b0;
                #1 chk("rand_reset", OUT, 1'b0);
                #9 RST_N = 1'b1;
            end
            cyc(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
